// File: rtl/mod_add_pipe_if.sv
// Handshake bundle for mod_add_pipe: operand channel (in_*) and result channel (out_*).
// Optional feature macro: MOD_ADD_RANGE_CHECK_EN adds the range_err result flag.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid must not depend on ready, and the payload is only meaningful while valid=1.
interface mod_add_pipe_if #(
  parameter int W = 48
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] Bop;
  logic [W-1:0] q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] R;
`ifdef MOD_ADD_RANGE_CHECK_EN
  logic         range_err;

  modport master (
    output in_valid, A, Bop, q, out_ready,
    input  in_ready, out_valid, R, range_err
  );
  modport slave (
    input  in_valid, A, Bop, q, out_ready,
    output in_ready, out_valid, R, range_err
  );
`else
  modport master (
    output in_valid, A, Bop, q, out_ready,
    input  in_ready, out_valid, R
  );
  modport slave (
    input  in_valid, A, Bop, q, out_ready,
    output in_ready, out_valid, R
  );
`endif
endinterface

// File: rtl/mod_add_pipe.sv
// Two-stage pipelined modular adder: R = (A + Bop) mod q, operands assumed < q.
// S1 registers the operand set; S2 registers the reduced result.
// Optional feature macro: MOD_ADD_RANGE_CHECK_EN flags operands >= q via range_err.
module mod_add_pipe #(
  parameter int W  = 48,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  mod_add_pipe_if.slave bus,
  output logic [CW-1:0] op_cnt
);

  logic         s1_valid_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] m_q;
  logic         out_valid_q;
  logic [W-1:0] r_q;
  logic [W-1:0] r_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic         adv2;
  logic         s1_load;
  logic         out_xfer;
  logic [W:0]   sum;
  logic [W:0]   mod_ext;

  // S2 may advance when it is empty or its result is being taken this cycle.
  assign adv2     = !out_valid_q || bus.out_ready;
  assign s1_load  = !s1_valid_q || adv2;
  assign out_xfer = out_valid_q && bus.out_ready;

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign op_cnt        = cnt_q;

  // Reduction: full W+1-bit sum so the carry takes part in the compare.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    mod_ext = {1'b0, m_q};
    r_d     = sum[W-1:0];
    if (sum >= mod_ext) begin
      r_d = W'(sum - mod_ext);
    end
  end

  // S1: capture an operand set; the valid bit clears when S1 drains with no new input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
    end else if (s1_load) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_q <= bus.A;
        b_q <= bus.Bop;
        m_q <= bus.q;
      end
    end
  end

  // S2: register the result; R only changes when a new valid result moves in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        r_q <= r_d;
      end
    end
  end

  // Completed-operation counter, wraps naturally at 2^CW.
  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef MOD_ADD_RANGE_CHECK_EN
  logic range_err_q;

  // Range flag travels with R through S2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      range_err_q <= 1'b0;
    end else if (adv2 && s1_valid_q) begin
      range_err_q <= (a_q >= m_q) || (b_q >= m_q);
    end
  end

  assign bus.range_err = range_err_q;
`endif

endmodule
